// File: rtl/logic_chain_pkg.sv
// Shared types and lane-level functions for the pipelined XOR/OR/AND chain.
// All operations are bitwise, so each function works on one lane and is replicated over WIDTH.
package logic_chain_pkg;

    typedef struct packed {
        logic x;
        logic o;
        logic a;
    } chain_state_t;

    function automatic int num_stages(input int iter, input int reg_every);
        return (iter + reg_every - 1) / reg_every;
    endfunction

    function automatic chain_state_t chain_seed(
        input logic a,
        input logic b,
        input logic c,
        input logic d,
        input logic e,
        input logic f
    );
        logic n1;
        logic n2;
        logic n3;
        chain_state_t s;
        n1  = ~(a & b);
        n2  = c | d;
        n3  = e ^ f;
        s.x = n3 | n1;
        s.o = (n1 & n2) | n3;
        s.a = (n2 ^ s.x) & s.o;
        return s;
    endfunction

    // Each field uses the already-updated value of the previous one.
    function automatic chain_state_t chain_step(input chain_state_t s);
        chain_state_t r;
        r.x = s.x ^ s.a;
        r.o = s.o | r.x;
        r.a = s.a & r.o;
        return r;
    endfunction

    // Returns {y1, y2, y3} for one lane.
    function automatic logic [2:0] chain_out(input chain_state_t s);
        return {s.x ^ s.a, s.o | s.a, s.a & s.x};
    endfunction

endpackage

// File: rtl/logic_chain_stage.sv
// One pipeline stage: applies N_STEPS chain iterations to the incoming state and
// holds the result plus its valid flag in an enabled register.
module logic_chain_stage
    import logic_chain_pkg::*;
#(
    parameter int WIDTH   = 4,
    parameter int N_STEPS = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic                     in_valid,
    input  chain_state_t [WIDTH-1:0] in_state,
    output logic                     out_valid,
    output chain_state_t [WIDTH-1:0] out_state
);

    chain_state_t [WIDTH-1:0] state_next;
    chain_state_t [WIDTH-1:0] state_reg;
    logic                     valid_reg;

    always_comb begin
        state_next = in_state;
        for (int l = 0; l < WIDTH; l++) begin
            for (int s = 0; s < N_STEPS; s++) begin
                state_next[l] = chain_step(state_next[l]);
            end
        end
    end

    // Data only moves with a valid word so the output holds its last result across bubbles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_reg <= 1'b0;
            state_reg <= '0;
        end else if (en) begin
            valid_reg <= in_valid;
            if (in_valid) begin
                state_reg <= state_next;
            end
        end
    end

    assign out_valid = valid_reg;
    assign out_state = state_reg;

endmodule

// File: rtl/logic_chain_pipe.sv
// Bit-sliced iterated XOR/OR/AND chain split into ceil(ITER/REG_EVERY) stages
// behind a bubble-collapsing valid/ready handshake.
module logic_chain_pipe
    import logic_chain_pkg::*;
#(
    parameter int WIDTH     = 4,
    parameter int ITER      = 4,
    parameter int REG_EVERY = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] c,
    input  logic [WIDTH-1:0] d,
    input  logic [WIDTH-1:0] e,
    input  logic [WIDTH-1:0] f,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] y1,
    output logic [WIDTH-1:0] y2,
    output logic [WIDTH-1:0] y3,
    output logic             out_valid,
    input  logic             out_ready
);

    localparam int S = num_stages(ITER, REG_EVERY);

    chain_state_t [WIDTH-1:0] seed_state;
    chain_state_t [WIDTH-1:0] stage_in_state [S];
    chain_state_t [WIDTH-1:0] stage_state    [S];
    logic [S-1:0]             stage_in_valid;
    logic [S-1:0]             stage_valid;
    logic [S-1:0]             stage_en;

    always_comb begin
        seed_state = '0;
        for (int l = 0; l < WIDTH; l++) begin
            seed_state[l] = chain_seed(a[l], b[l], c[l], d[l], e[l], f[l]);
        end
    end

    // A stage may load when it is empty or when everything downstream can advance.
    always_comb begin
        stage_en        = '0;
        stage_en[S-1]   = ~stage_valid[S-1] | out_ready;
        for (int k = S - 2; k >= 0; k--) begin
            stage_en[k] = ~stage_valid[k] | stage_en[k+1];
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < S; gi++) begin : g_stage
            localparam int STEPS = (gi == S - 1) ? (ITER - (S - 1) * REG_EVERY) : REG_EVERY;

            if (gi == 0) begin : g_head
                assign stage_in_state[gi] = seed_state;
                assign stage_in_valid[gi] = in_valid;
            end else begin : g_body
                assign stage_in_state[gi] = stage_state[gi-1];
                assign stage_in_valid[gi] = stage_valid[gi-1];
            end

            logic_chain_stage #(
                .WIDTH   (WIDTH),
                .N_STEPS (STEPS)
            ) u_stage (
                .clk       (clk),
                .rst       (rst),
                .en        (stage_en[gi]),
                .in_valid  (stage_in_valid[gi]),
                .in_state  (stage_in_state[gi]),
                .out_valid (stage_valid[gi]),
                .out_state (stage_state[gi])
            );
        end
    endgenerate

    always_comb begin
        y1 = '0;
        y2 = '0;
        y3 = '0;
        for (int l = 0; l < WIDTH; l++) begin
            {y1[l], y2[l], y3[l]} = chain_out(stage_state[S-1][l]);
        end
    end

    assign in_ready  = stage_en[0];
    assign out_valid = stage_valid[S-1];

endmodule

// File: tb/tb_logic_chain_pipe.sv
// Directed and streaming checks of logic_chain_pipe across several WIDTH/ITER/REG_EVERY
// configurations, each result compared with hand values or an independent lane model.
module tb_logic_chain_pipe;

    localparam int N_DUT = 5;
    localparam int W_T [N_DUT] = '{4, 1, 1, 4, 4};
    localparam int I_T [N_DUT] = '{4, 4, 3, 4, 4};
    localparam int R_T [N_DUT] = '{2, 2, 2, 1, 4};
    localparam int S_T [N_DUT] = '{2, 2, 2, 4, 1};

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  a, b, c, d, e, f;
    logic        in_valid  [N_DUT];
    logic        out_ready [N_DUT];
    logic        in_ready  [N_DUT];
    logic        out_valid [N_DUT];
    logic [11:0] res       [N_DUT];

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    genvar gi;
    generate
        for (gi = 0; gi < N_DUT; gi++) begin : g_dut
            localparam int W = W_T[gi];
            logic [W-1:0] y1_l, y2_l, y3_l;

            logic_chain_pipe #(
                .WIDTH     (W),
                .ITER      (I_T[gi]),
                .REG_EVERY (R_T[gi])
            ) u_dut (
                .clk       (clk),
                .rst       (rst),
                .a         (a[W-1:0]),
                .b         (b[W-1:0]),
                .c         (c[W-1:0]),
                .d         (d[W-1:0]),
                .e         (e[W-1:0]),
                .f         (f[W-1:0]),
                .in_valid  (in_valid[gi]),
                .in_ready  (in_ready[gi]),
                .y1        (y1_l),
                .y2        (y2_l),
                .y3        (y3_l),
                .out_valid (out_valid[gi]),
                .out_ready (out_ready[gi])
            );

            assign res[gi] = {4'(y1_l), 4'(y2_l), 4'(y3_l)};
        end
    endgenerate

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end else begin
            $display("ok   %s: %0h", tag, got);
        end
    endtask

    // Lane-by-lane reference; ops = {a,b,c,d,e,f}, result = {y1,y2,y3}.
    function automatic logic [11:0] model(input logic [23:0] ops, input int iter, input int w);
        logic [3:0]  r1, r2, r3;
        logic        n1, n2, n3, x, o, an;
        logic [11:0] r;
        for (int l = 0; l < 4; l++) begin
            n1 = ~(ops[20+l] & ops[16+l]);
            n2 = ops[12+l] | ops[8+l];
            n3 = ops[4+l] ^ ops[l];
            x  = n3 | n1;
            o  = (n1 & n2) | n3;
            an = (n2 ^ x) & o;
            for (int i = 0; i < iter; i++) begin
                x  = x ^ an;
                o  = o | x;
                an = an & o;
            end
            r1[l] = x ^ an;
            r2[l] = o | an;
            r3[l] = an & x;
        end
        r = {r1, r2, r3};
        if (w == 1) r = r & 12'h111;
        return r;
    endfunction

    task automatic drive_ops(input logic [23:0] ops);
        {a, b, c, d, e, f} = ops;
    endtask

    // Single transfer into an empty pipe: checks acceptance, latency in edges, and result.
    task automatic run_one(input int idx, input logic [23:0] ops, input logic [11:0] exp,
                           input string tag);
        int n;
        int lat;
        @(negedge clk);
        drive_ops(ops);
        in_valid[idx]  = 1'b1;
        out_ready[idx] = 1'b1;
        #1;
        n = 0;
        while (!in_ready[idx] && n < 20) begin
            @(negedge clk);
            #1;
            n++;
        end
        check({tag, " in_ready"}, 32'(in_ready[idx]), 32'd1);
        @(posedge clk);
        #1;
        in_valid[idx] = 1'b0;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!out_valid[idx] && lat < 20);
        check({tag, " latency"}, lat, S_T[idx]);
        check({tag, " result"}, 32'(res[idx]), 32'(exp));
    endtask

    // Random stream with out_ready held low for the first `stall` cycles.
    task automatic run_stream(input int idx, input int n_vec, input int stall, input string tag);
        logic [23:0] vecs[$];
        logic [11:0] exp_q[$];
        logic [11:0] held;
        logic [11:0] exp_v;
        logic [31:0] rnd;
        logic        was_stalled;
        logic        acc, ret;
        int          sent, got, occ, cyc, last_cyc;
        sent = 0; got = 0; occ = 0; cyc = 0; last_cyc = -1;
        was_stalled = 1'b0;
        held = '0;
        for (int i = 0; i < n_vec; i++) begin
            rnd = $urandom;
            vecs.push_back(rnd[23:0]);
        end
        while (got < n_vec && cyc < 100) begin
            @(negedge clk);
            out_ready[idx] = (cyc >= stall);
            if (sent < n_vec) begin
                drive_ops(vecs[sent]);
                in_valid[idx] = 1'b1;
            end else begin
                in_valid[idx] = 1'b0;
            end
            #1;
            check($sformatf("%s in_ready c%0d", tag, cyc), 32'(in_ready[idx]),
                  32'(!(occ == S_T[idx] && !out_ready[idx])));
            if (was_stalled) begin
                check($sformatf("%s hold y c%0d", tag, cyc), 32'(res[idx]), 32'(held));
                check($sformatf("%s hold valid c%0d", tag, cyc), 32'(out_valid[idx]), 32'd1);
            end
            acc = in_valid[idx] && in_ready[idx];
            ret = out_valid[idx] && out_ready[idx];
            if (ret) begin
                if (exp_q.size() == 0) begin
                    check($sformatf("%s spurious c%0d", tag, cyc), 32'(out_valid[idx]), 32'd0);
                end else begin
                    exp_v = exp_q.pop_front();
                    check($sformatf("%s out%0d", tag, got), 32'(res[idx]), 32'(exp_v));
                    got++;
                    last_cyc = cyc;
                end
            end
            was_stalled = out_valid[idx] && !out_ready[idx];
            held = res[idx];
            if (acc) begin
                exp_q.push_back(model(vecs[sent], I_T[idx], W_T[idx]));
                sent++;
            end
            occ = occ + int'(acc) - int'(ret);
            cyc++;
        end
        in_valid[idx] = 1'b0;
        check({tag, " delivered"}, got, n_vec);
        if (stall == 0) check({tag, " last out cycle"}, last_cyc, n_vec - 1 + S_T[idx]);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        drive_ops(24'h0);
        for (int i = 0; i < N_DUT; i++) begin
            in_valid[i]  = 1'b0;
            out_ready[i] = 1'b1;
        end
        #1;
        for (int i = 0; i < N_DUT; i++) begin
            check($sformatf("reset dut%0d in_ready", i), 32'(in_ready[i]), 32'd1);
            check($sformatf("reset dut%0d out_valid", i), 32'(out_valid[i]), 32'd0);
            check($sformatf("reset dut%0d y", i), 32'(res[i]), 32'd0);
        end
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Hand-computed vectors
        run_one(1, 24'h000000, 12'h110, "scalar zeros");
        run_one(0, 24'hAA80C0, 12'h9D4, "w4 vector");
        run_one(1, 24'h000010, 12'h011, "parity iter4");
        run_one(2, 24'h000010, 12'h110, "parity iter3");
        run_one(0, 24'h0000F0, 12'h0FF, "w4 e-only");

        run_stream(0, 8, 5, "backpressure");

        // Reset with two entries in flight
        @(negedge clk);
        out_ready[0] = 1'b0;
        drive_ops(24'hAA80C0);
        in_valid[0] = 1'b1;
        @(negedge clk);
        drive_ops(24'h000010);
        @(negedge clk);
        in_valid[0] = 1'b0;
        #1;
        check("pre-reset out_valid", 32'(out_valid[0]), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check("async reset out_valid", 32'(out_valid[0]), 32'd0);
        check("async reset y", 32'(res[0]), 32'd0);
        check("async reset in_ready", 32'(in_ready[0]), 32'd1);
        @(negedge clk);
        check("in reset in_ready", 32'(in_ready[0]), 32'd1);
        rst = 1'b0;
        out_ready[0] = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check($sformatf("post-reset idle c%0d", i), 32'(out_valid[0]), 32'd0);
        end
        run_one(0, 24'hAA80C0, 12'h9D4, "post-reset vector");

        // REG_EVERY sweep: same function, different depth
        run_one(3, 24'hAA80C0, 12'h9D4, "re1 vector");
        run_one(4, 24'hAA80C0, 12'h9D4, "re4 vector");
        run_stream(0, 6, 0, "stream re2");
        run_stream(3, 6, 0, "stream re1");
        run_stream(4, 6, 0, "stream re4");

        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
